// File: rtl/conv_window_sequencer_if.sv
// Signal bundle shared by the pixel source, the window sequencer, the conv datapath and the result consumer.
// master = sequencer side, slave = environment side.
interface conv_window_sequencer_if #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic                                     start;
  logic signed [WIDTH_BIT-1:0]              pix_in;
  logic                                     pix_valid;
  logic                                     pix_ready;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_out;
  logic signed [WIDTH_BIT-1:0]              conv_result;
  logic signed [WIDTH_BIT-1:0]              res_out;
  logic [RW-1:0]                            res_row;
  logic [CW-1:0]                            res_col;
  logic                                     res_valid;
  logic                                     res_ready;
  logic                                     busy;
  logic                                     done;

  modport master (
    input  start, pix_in, pix_valid, conv_result, res_ready,
    output pix_ready, win_out, res_out, res_row, res_col, res_valid, busy, done
  );
  modport slave (
    output start, pix_in, pix_valid, conv_result, res_ready,
    input  pix_ready, win_out, res_out, res_row, res_col, res_valid, busy, done
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Raster-order pixel stream -> sliding SIZE x SIZE window (SIZE-1 line buffers) -> registered,
// position-tagged conv results on a valid/ready port.
module conv_window_sequencer #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input logic                     clock,
  input logic                     reset,
  conv_window_sequencer_if.master bus
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W-1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H-1);
  localparam logic [CW-1:0] C_MIN  = CW'(SIZE-1);
  localparam logic [RW-1:0] R_MIN  = RW'(SIZE-1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;

  logic [RW-1:0] r, pend_row, res_row_q;
  logic [CW-1:0] c, pend_col, res_col_q;
  logic          pend, rv, acc, cap, win_ok;
  logic [WIDTH_BIT-1:0]                     lb [SIZE-1][IMG_W];
  logic [SIZE-1:0][WIDTH_BIT-1:0]           newcol;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win;
  logic signed [WIDTH_BIT-1:0]              res_q;

  // Stall input only when a pending window cannot be moved into a blocked output register.
  assign bus.pix_ready = (state == RUN) && !(pend && rv && !bus.res_ready);
  assign acc           = bus.pix_valid && bus.pix_ready;
  assign cap           = pend && (!rv || bus.res_ready);
  assign win_ok        = (r >= R_MIN) && (c >= C_MIN);

  assign bus.win_out   = win;
  assign bus.res_out   = res_q;
  assign bus.res_row   = res_row_q;
  assign bus.res_col   = res_col_q;
  assign bus.res_valid = rv;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (acc && r == R_LAST && c == C_LAST) state_nx = FLUSH;
      FLUSH:   if (!pend && (!rv || bus.res_ready)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // New rightmost window column: oldest line buffer row first, live pixel last.
  always_comb begin
    newcol = '0;
    for (int k = 0; k < SIZE-1; k++) newcol[k] = lb[k][c];
    newcol[SIZE-1] = bus.pix_in;
  end

  always_ff @(posedge clock) begin
    if (acc) begin
      for (int k = 0; k < SIZE-2; k++) lb[k][c] <= lb[k+1][c];
      lb[SIZE-2][c] <= bus.pix_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r         <= '0;
      c         <= '0;
      pend      <= 1'b0;
      pend_row  <= '0;
      pend_col  <= '0;
      win       <= '0;
      res_q     <= '0;
      res_row_q <= '0;
      res_col_q <= '0;
      rv        <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        r <= '0;
        c <= '0;
      end
      if (acc) begin
        c <= (c == C_LAST) ? '0 : c + CW'(1);
        if (c == C_LAST) r <= r + RW'(1);
        for (int i = 0; i < SIZE; i++) win[i] <= {newcol[i], win[i][SIZE-1:1]};
        if (win_ok) begin
          pend_row <= r - R_MIN;
          pend_col <= c - C_MIN;
        end
      end
      // Windows straddling a row wrap or the first SIZE-1 rows never set pend.
      if (acc && win_ok) pend <= 1'b1;
      else if (cap)      pend <= 1'b0;
      if (cap) begin
        res_q     <= bus.conv_result;
        res_row_q <= pend_row;
        res_col_q <= pend_col;
        rv        <= 1'b1;
      end else if (rv && bus.res_ready) begin
        rv <= 1'b0;
      end
    end
  end
endmodule
